// File: rtl/alu_pipe_pkg.sv
// Shared definitions for alu_pipe: opcode encodings, controller states and
// the bit positions of the status flags inside the registered flag vector.
package alu_pipe_pkg;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_MUL  = 4'd2;
   localparam logic [3:0] OP_RSVD = 4'd3;
   localparam logic [3:0] OP_SHL1 = 4'd4;
   localparam logic [3:0] OP_SHR1 = 4'd5;
   localparam logic [3:0] OP_ROL1 = 4'd6;
   localparam logic [3:0] OP_ROR1 = 4'd7;
   localparam logic [3:0] OP_AND  = 4'd8;
   localparam logic [3:0] OP_OR   = 4'd9;
   localparam logic [3:0] OP_XOR  = 4'd10;
   localparam logic [3:0] OP_NOR  = 4'd11;
   localparam logic [3:0] OP_NAND = 4'd12;
   localparam logic [3:0] OP_XNOR = 4'd13;
   localparam logic [3:0] OP_GT   = 4'd14;
   localparam logic [3:0] OP_EQ   = 4'd15;

   typedef enum logic {
      IDLE    = 1'b0,
      MUL_RUN = 1'b1
   } state_e;

   localparam int FLAG_CARRY    = 0;
   localparam int FLAG_OVERFLOW = 1;
   localparam int FLAG_ZERO     = 2;
   localparam int FLAG_NEGATIVE = 3;
   localparam int FLAG_ILLEGAL  = 4;
   localparam int NUM_FLAGS     = 5;

   typedef logic [NUM_FLAGS-1:0] flags_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Sequential shift-add multiplier: one partial product per clock, WIDTH
// iterations after start; done and product are valid in the final cycle.
module alu_mul_seq #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               busy_q, busy_d;

   always_comb begin
      // NOTE: every always_comb output gets a default first, otherwise a
      // path that skips an assignment infers a latch.
      mcand_d  = mcand_q;
      acc_d    = acc_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      if (start) begin
         mcand_d  = {{WIDTH{1'b0}}, a};
         mplier_d = b;
         acc_d    = '0;
         cnt_d    = '0;
         busy_d   = 1'b1;
      end else if (busy_q) begin
         acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + 1'b1;
         if (cnt_q == LAST) begin
            busy_d = 1'b0;
            cnt_d  = '0;
         end
      end
   end

   // The last iteration's sum is forwarded so the top can register it on the
   // same edge the multiplier retires.
   assign done    = busy_q && (cnt_q == LAST);
   assign product = acc_d;

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (!rst_n) begin
         mcand_q  <= '0;
         acc_q    <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
      end else begin
         mcand_q  <= mcand_d;
         acc_q    <= acc_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
      end
   end

endmodule

// File: rtl/alu_pipe.sv
// Valid/ready ALU with registered result and flags. Define ALU_PIPE_MUL_EN to
// build the multi-cycle MUL; otherwise MUL is treated as the reserved opcode.
module alu_pipe
   import alu_pipe_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             overflow,
   output logic             zero,
   output logic             negative,
   output logic             illegal
);

   state_e             state_q, state_d;
   logic               out_valid_q, out_valid_d;
   logic [WIDTH-1:0]   result_q, result_d;
   flags_t             flags_q, flags_d;

   logic [WIDTH-1:0]   alu_res;
   flags_t             alu_flags;
   logic               alu_carry, alu_ovf, alu_ill;
   logic [WIDTH:0]     sum, diff;
   logic               accept;

   assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;

   always_comb begin
      sum       = {1'b0, a} + {1'b0, b};
      diff      = {1'b0, a} - {1'b0, b};
      alu_res   = '0;
      alu_carry = 1'b0;
      alu_ovf   = 1'b0;
      alu_ill   = 1'b0;
      case (op)
         OP_ADD: begin
            alu_res   = sum[WIDTH-1:0];
            alu_carry = sum[WIDTH];
            alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res   = diff[WIDTH-1:0];
            alu_carry = diff[WIDTH];
            alu_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SHL1: begin
            alu_res   = {a[WIDTH-2:0], 1'b0};
            alu_carry = a[WIDTH-1];
         end
         OP_SHR1: begin
            alu_res   = {1'b0, a[WIDTH-1:1]};
            alu_carry = a[0];
         end
         OP_ROL1: begin
            alu_res   = {a[WIDTH-2:0], a[WIDTH-1]};
            alu_carry = a[WIDTH-1];
         end
         OP_ROR1: begin
            alu_res   = {a[0], a[WIDTH-1:1]};
            alu_carry = a[0];
         end
         OP_AND:  alu_res = a & b;
         OP_OR:   alu_res = a | b;
         OP_XOR:  alu_res = a ^ b;
         OP_NOR:  alu_res = ~(a | b);
         OP_NAND: alu_res = ~(a & b);
         OP_XNOR: alu_res = ~(a ^ b);
         OP_GT:   alu_res = {{(WIDTH-1){1'b0}}, (a > b)};
         OP_EQ:   alu_res = {{(WIDTH-1){1'b0}}, (a == b)};
         // Reserved opcode, and MUL whenever the multiplier is not built.
         default: alu_ill = 1'b1;
      endcase

      alu_flags                = '0;
      alu_flags[FLAG_CARRY]    = alu_carry;
      alu_flags[FLAG_OVERFLOW] = alu_ovf;
      alu_flags[FLAG_ZERO]     = (alu_res == '0);
      alu_flags[FLAG_NEGATIVE] = alu_res[WIDTH-1];
      alu_flags[FLAG_ILLEGAL]  = alu_ill;
   end

`ifdef ALU_PIPE_MUL_EN
   logic               mul_start;
   logic               mul_done;
   logic [2*WIDTH-1:0] mul_product;

   alu_mul_seq #(
      .WIDTH (WIDTH)
   ) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (mul_start),
      .a       (a),
      .b       (b),
      .done    (mul_done),
      .product (mul_product)
   );
`endif

   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q && !out_ready;
      result_d    = result_q;
      flags_d     = flags_q;
`ifdef ALU_PIPE_MUL_EN
      mul_start   = 1'b0;
      if (accept && (op == OP_MUL)) begin
         state_d   = MUL_RUN;
         mul_start = 1'b1;
      end else if (accept) begin
         out_valid_d = 1'b1;
         result_d    = alu_res;
         flags_d     = alu_flags;
      end
      // out_valid is always clear while MUL_RUN, so retiring cannot clobber
      // an unconsumed result.
      if ((state_q == MUL_RUN) && mul_done) begin
         state_d                = IDLE;
         out_valid_d            = 1'b1;
         result_d               = mul_product[WIDTH-1:0];
         flags_d                = '0;
         flags_d[FLAG_CARRY]    = |mul_product[2*WIDTH-1:WIDTH];
         flags_d[FLAG_ZERO]     = (mul_product[WIDTH-1:0] == '0);
         flags_d[FLAG_NEGATIVE] = mul_product[WIDTH-1];
      end
`else
      if (accept) begin
         out_valid_d = 1'b1;
         result_d    = alu_res;
         flags_d     = alu_flags;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         flags_q     <= '0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         flags_q     <= flags_d;
      end
   end

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign carry     = flags_q[FLAG_CARRY];
   assign overflow  = flags_q[FLAG_OVERFLOW];
   assign zero      = flags_q[FLAG_ZERO];
   assign negative  = flags_q[FLAG_NEGATIVE];
   assign illegal   = flags_q[FLAG_ILLEGAL];

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe (WIDTH=8): directed corner cases, a stalled
// opcode stream, mid-operation reset and randomized traffic against a model.
module tb_alu_pipe;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a, b;
   logic [3:0]   op;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         carry, overflow, zero, negative, illegal;
   logic [4:0]   dut_flags;

   typedef struct {
      logic [7:0] res;
      logic [4:0] flags;   // {illegal, negative, zero, overflow, carry}
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   ready_mode = 0;   // 0: always 1, 1: toggle, 2: random, 3: held low

   alu_pipe #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .carry     (carry),
      .overflow  (overflow),
      .zero      (zero),
      .negative  (negative),
      .illegal   (illegal)
   );

   assign dut_flags = {illegal, negative, zero, overflow, carry};

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference behaviour from the opcode definitions, in plain integers.
   function automatic exp_t model(input int ia, input int ib, input int iop);
      exp_t e;
      int   r, sa, sb, sr;
      bit   c, v, il;
      r = 0; c = 0; v = 0; il = 0; sr = 0;
      sa = (ia >= 128) ? ia - 256 : ia;
      sb = (ib >= 128) ? ib - 256 : ib;
      case (iop)
         0: begin r = (ia + ib) % 256; c = (ia + ib) > 255; sr = sa + sb; v = (sr > 127) || (sr < -128); end
         1: begin r = (ia - ib + 256) % 256; c = ia < ib; sr = sa - sb; v = (sr > 127) || (sr < -128); end
         2: begin
`ifdef ALU_PIPE_MUL_EN
            r = (ia * ib) % 256; c = (ia * ib) > 255;
`else
            il = 1;
`endif
         end
         4:  begin r = (ia * 2) % 256; c = ia >= 128; end
         5:  begin r = ia / 2; c = (ia % 2) == 1; end
         6:  begin r = (ia * 2) % 256 + ia / 128; c = ia >= 128; end
         7:  begin r = ia / 2 + (ia % 2) * 128; c = (ia % 2) == 1; end
         8:  r = ia & ib;
         9:  r = ia | ib;
         10: r = ia ^ ib;
         11: r = 255 - (ia | ib);
         12: r = 255 - (ia & ib);
         13: r = 255 - (ia ^ ib);
         14: r = (ia > ib) ? 1 : 0;
         15: r = (ia == ib) ? 1 : 0;
         default: il = 1;
      endcase
      e.res   = r[7:0];
      e.flags = {il, (r >= 128), (r == 0), v, c};
      return e;
   endfunction

   // Output-side handshake driver.
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = !out_ready;
            2:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
         endcase
      end
   end

   // Monitor: pops the scoreboard on each transfer and checks stall stability.
   initial begin
      exp_t       e;
      bit         held_valid;
      logic [7:0] held_res;
      logic [4:0] held_flags;
      held_valid = 0;
      held_res   = '0;
      held_flags = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            held_valid = 0;
         end else begin
            if (held_valid) begin
               check("stall_valid", 32'(out_valid), 32'd1);
               check("stall_result", 32'(result), 32'(held_res));
               check("stall_flags", 32'(dut_flags), 32'(held_flags));
            end
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_output: got result 0x%0h with empty scoreboard (t=%0t)", result, $time);
               end else begin
                  e = exp_q.pop_front();
                  check("sb_result", 32'(result), 32'(e.res));
                  check("sb_flags", 32'(dut_flags), 32'(e.flags));
               end
               held_valid = 0;
            end else if (out_valid) begin
               held_valid = 1;
               held_res   = result;
               held_flags = dut_flags;
            end else begin
               held_valid = 0;
            end
         end
      end
   end

   // Presents one request, holds it until accepted, and logs the expectation.
   task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic [3:0] iop,
                        output int waited);
      bit done;
      done     = 0;
      waited   = 0;
      in_valid = 1'b1;
      a        = ia;
      b        = ib;
      op       = iop;
      while (!done) begin
         @(negedge clk);
         if (in_ready) begin
            exp_q.push_back(model(int'(ia), int'(ib), int'(iop)));
            done = 1;
         end else if (waited >= 60) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: op %0d not accepted after %0d cycles", iop, waited);
            done = 1;
         end else begin
            waited++;
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic run_dir(input string name, input logic [7:0] ia, input logic [7:0] ib,
                          input logic [3:0] iop, input logic [7:0] req_res,
                          input logic [4:0] req_flags, input int req_lat);
      int w, lat;
      bit seen, busy_ok;
      ready_mode = 0;
      out_ready  = 1'b1;
      issue(ia, ib, iop, w);
      lat = 0; seen = 0; busy_ok = 1;
      while (!seen && lat < 40) begin
         @(negedge clk);
         lat++;
         if (out_valid) seen = 1;
         else if (in_ready) busy_ok = 0;
      end
      check({name, "_latency"}, 32'(lat), 32'(req_lat));
      check({name, "_result"}, 32'(result), 32'(req_res));
      check({name, "_flags"}, 32'(dut_flags), 32'(req_flags));
      if (req_lat > 1) check({name, "_busy_not_ready"}, 32'(busy_ok), 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n;
      ready_mode = 0;
      out_ready  = 1'b1;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("drain_empty", 32'(exp_q.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] pick();
      logic [7:0] corners [5];
      corners = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};
      if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
      return 8'($urandom);
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int  w;
      bit  seen;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      a        = '0;
      b        = '0;
      op       = '0;
      repeat (3) @(negedge clk);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_result", 32'(result), 32'd0);
      check("reset_flags", 32'(dut_flags), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("post_reset_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;

      // Directed corner cases; flags are {illegal, negative, zero, overflow, carry}.
      run_dir("add_basic", 8'h0A, 8'h02, 4'd0, 8'h0C, 5'b00000, 1);
      run_dir("add_carry", 8'hF6, 8'h0A, 4'd0, 8'h00, 5'b00101, 1);
      run_dir("sub_borrow", 8'h02, 8'h0A, 4'd1, 8'hF8, 5'b01001, 1);
      run_dir("add_ovf", 8'h7F, 8'h01, 4'd0, 8'h80, 5'b01010, 1);
      run_dir("rsvd", 8'h55, 8'h33, 4'd3, 8'h00, 5'b10100, 1);
`ifdef ALU_PIPE_MUL_EN
      run_dir("mul_small", 8'h0A, 8'h02, 4'd2, 8'h14, 5'b00000, 8);
      run_dir("mul_wide", 8'h10, 8'h10, 4'd2, 8'h00, 5'b00101, 8);
`else
      run_dir("mul_off", 8'h0A, 8'h02, 4'd2, 8'h00, 5'b10100, 1);
`endif
      run_dir("shl_carry", 8'h81, 8'h00, 4'd4, 8'h02, 5'b00001, 1);
      run_dir("ror_wrap", 8'h01, 8'h00, 4'd7, 8'h80, 5'b01001, 1);
      run_dir("gt_true", 8'h05, 8'h03, 4'd14, 8'h01, 5'b00000, 1);
      run_dir("eq_true", 8'h05, 8'h05, 4'd15, 8'h01, 5'b00000, 1);
      run_dir("nor_zero", 8'h00, 8'h00, 4'd11, 8'hFF, 5'b01000, 1);

      // Back-to-back acceptance with the consumer always ready.
      for (int i = 0; i < 4; i++) begin
         issue(8'(i * 17), 8'(i + 1), 4'd0, w);
         check("b2b_wait", 32'(w), 32'd0);
      end
      drain();

      // Reset pulsed while an operation is in flight (MUL) or stalled.
      ready_mode = 3;
      out_ready  = 1'b0;
      issue(8'h0A, 8'h02, 4'd2, w);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_result", 32'(result), 32'd0);
      check("midrst_flags", 32'(dut_flags), 32'd0);
      @(posedge clk);
      #1;
      rst_n      = 1'b1;
      ready_mode = 0;
      out_ready  = 1'b1;
      @(negedge clk);
      check("midrst_ready", 32'(in_ready), 32'd1);
      seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (out_valid) seen = 1;
      end
      check("midrst_no_result", 32'(seen), 32'd0);
      @(posedge clk);
      #1;
      run_dir("after_rst_add", 8'h01, 8'h01, 4'd0, 8'h02, 5'b00000, 1);

      // All opcodes streamed against a consumer toggling ready every cycle.
      ready_mode = 1;
      for (int o = 0; o < 16; o++) issue(pick(), pick(), 4'(o), w);
      drain();

      // Randomized traffic with random back-pressure and idle gaps.
      ready_mode = 2;
      for (int i = 0; i < 300; i++) begin
         issue(pick(), pick(), 4'($urandom_range(0, 15)), w);
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
      end
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width, legal range 4..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  operation request valid.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 a  input  WIDTH  operand A.
REQ-007 b  input  WIDTH  operand B.
REQ-008 op  input  4  opcode select.
REQ-009 out_valid  output  1  result and flags valid.
REQ-010 out_ready  input  1  consumer accepts the result this cycle.
REQ-011 result  output  WIDTH  registered result.
REQ-012 carry, overflow, zero, negative, illegal  output  1 each  registered status flags.

Function
REQ-013 Opcodes SHALL be: 0 ADD, 1 SUB, 2 MUL, 3 reserved, 4 SHL1, 5 SHR1, 6 ROL1, 7 ROR1, 8 AND, 9 OR, 10 XOR, 11 NOR, 12 NAND, 13 XNOR, 14 GT (unsigned, result 1/0), 15 EQ (result 1/0).
REQ-014 A request SHALL be accepted on a rising edge where in_valid && in_ready, and the operands SHALL be captured at that edge.
REQ-015 in_ready SHALL equal (state==IDLE) && (!out_valid || out_ready).
REQ-016 Single-cycle ops SHALL assert out_valid on the edge after acceptance; back-to-back acceptance gives one result per cycle while out_ready=1.
REQ-017 result/flags SHALL hold stable while out_valid && !out_ready; out_valid SHALL clear on an edge with out_ready=1 and no new completion.
REQ-018 FSM states SHALL be IDLE, MUL_RUN, with IDLE->MUL_RUN on accepting MUL and MUL_RUN->IDLE after exactly WIDTH iterations, asserting out_valid on that same edge.
REQ-019 ADD/SUB SHALL be modulo 2^WIDTH; carry=carry-out (ADD) or borrow, i.e. a<b unsigned (SUB); overflow=two's-complement signed overflow.
REQ-020 SHL1 carry SHALL be a[WIDTH-1]; SHR1 carry SHALL be a[0]; rotates SHALL set carry to the bit that wrapped.
REQ-021 MUL SHALL return the low WIDTH bits of a*b (unsigned); carry SHALL be 1 iff the high WIDTH bits are non-zero.
REQ-022 zero SHALL be (result==0); negative SHALL be result[WIDTH-1]; carry/overflow SHALL be 0 for ops not listed above.
REQ-023 Opcode 3 SHALL complete single-cycle with result 0, illegal=1, zero=1, all other flags 0.
REQ-024 in_valid while in_ready=0 SHALL be ignored; the requester SHALL hold its request until accepted.

Reset
REQ-025 While rst_n=0: state=IDLE, out_valid=0, result=0, all flags 0, multiplier iteration counter=0.
REQ-026 Reset asserted mid-MUL SHALL abort the operation; no out_valid for it after release.
REQ-027 in_ready SHALL be 1 on the first edge after reset release.

Configuration
REQ-028 Macro ALU_PIPE_MUL_EN: when defined, MUL SHALL be implemented per REQ-018/021.
REQ-029 When ALU_PIPE_MUL_EN is undefined, MUL SHALL behave exactly as opcode 3 (REQ-023), MUL_RUN SHALL be unreachable and no multiplier logic SHALL be instantiated.

Structure
REQ-030 Package alu_pipe_pkg SHALL hold the opcode constants, FSM state encoding, and flag bit positions.
REQ-031 Sub-module alu_mul_seq SHALL implement the shift-add multiplier (start, a, b -> done, 2*WIDTH product), instantiated only under ALU_PIPE_MUL_EN.

Verification
REQ-032 WIDTH=8, A=0x0A, B=0x02, op ADD -> result 0x0C, all flags 0, out_valid one edge after accept.
REQ-033 A=0xF6, B=0x0A, ADD -> result 0x00, carry=1, zero=1; SUB 0x02-0x0A -> 0xF8, carry=1, negative=1; ADD 0x7F+0x01 -> 0x80, overflow=1.
REQ-034 Macro defined: MUL 0x0A*0x02 -> 0x14 after 8 cycles, in_ready=0 throughout; MUL 0x10*0x10 -> 0x00, carry=1.
REQ-035 op=3 (and op=2 with macro undefined) -> result 0x00, illegal=1, zero=1, single-cycle latency.
REQ-036 Stream all 16 opcodes with out_ready toggling 1/0 each cycle -> no result lost or duplicated; result stable while stalled.
REQ-037 rst_n pulsed low 3 cycles into MUL -> out_valid=0, state IDLE; next ADD 0x01+0x01 -> 0x02.
